// File: rtl/otf_quo_conv4.sv
// otf_quo_conv4 - radix-4 on-the-fly quotient converter for the SRT divider.
//
// Takes one signed radix-4 digit per accepted cycle and keeps two running
// registers, Q and QM = Q - 1 ulp. Each new digit only appends two bits to
// one of them, so no carry-propagate adder sits in the digit path.
//
// Optional feature macro: OTF_REM_CORR_EN. When it is defined, rem_neg is
// captured with the last digit and selects QM as the result, which corrects
// the quotient for a negative final remainder. When it is undefined, rem_neg
// is ignored and the result is always Q.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   start     one-cycle pulse; (re)starts a conversion, also aborts one
//   qj_valid  qj carries a digit this cycle
//   qj        one-hot digit: [3]=+2 [2]=+1 [1]=-1 [0]=-2, 0000 = 0
//   rem_neg   final remainder is negative (sampled with the last digit)
//   busy      conversion in progress
//   done      one-cycle pulse, quotient is final
//   quotient  two's-complement quotient, 2*NDIG bits
//   q_err     sticky: an illegal qj code was seen since the last start
module otf_quo_conv4 #(
  parameter int NDIG = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              qj_valid,
  input  logic [3:0]        qj,
  input  logic              rem_neg,
  output logic              busy,
  output logic              done,
  output logic [2*NDIG-1:0] quotient,
  output logic              q_err
);

  localparam int W  = 2 * NDIG;
  localparam int CW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t         state, state_n;
  logic [W-1:0]   q_r, qm_r;
  logic [CW-1:0]  cnt;
  logic           err_r;

  logic           accept, last, illegal;
  logic           q_src_qm, qm_src_qm;  // 1: take the QM register as the base
  logic [1:0]     q_app, qm_app;

  // A digit is taken only in CONV; start has priority over a same-cycle digit.
  assign accept  = (state == CONV) && qj_valid && !start;
  assign last    = (cnt == CW'(NDIG - 1));
  // More than one bit set in the one-hot code.
  assign illegal = (qj & (qj - 4'd1)) != 4'd0;

  // Digit decode. Q takes {Q, q} for q >= 0 and {QM, 4+q} for q < 0;
  // QM takes {Q, q-1} for q > 0 and {QM, 3+q} for q <= 0.
  // Zero and illegal codes both fall through to the q = 0 case.
  always_comb begin
    q_src_qm  = 1'b0;
    q_app     = 2'b00;
    qm_src_qm = 1'b1;
    qm_app    = 2'b11;
    case (qj)
      4'b1000: begin q_app = 2'b10; qm_src_qm = 1'b0; qm_app = 2'b01; end
      4'b0100: begin q_app = 2'b01; qm_src_qm = 1'b0; qm_app = 2'b00; end
      4'b0010: begin q_src_qm = 1'b1; q_app = 2'b11; qm_app = 2'b10; end
      4'b0001: begin q_src_qm = 1'b1; q_app = 2'b10; qm_app = 2'b01; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start) begin
      state_n = CONV;
    end else begin
      case (state)
        CONV:    if (accept && last) state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r   <= '0;
      qm_r  <= '0;
      cnt   <= '0;
      err_r <= 1'b0;
    end else if (start) begin
      q_r   <= '0;
      qm_r  <= '1;
      cnt   <= '0;
      err_r <= 1'b0;
    end else if (accept) begin
      q_r   <= {(q_src_qm  ? qm_r[W-3:0] : q_r[W-3:0]), q_app};
      qm_r  <= {(qm_src_qm ? qm_r[W-3:0] : q_r[W-3:0]), qm_app};
      cnt   <= cnt + CW'(1);
      err_r <= err_r | illegal;
    end
  end

`ifdef OTF_REM_CORR_EN
  logic rem_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                rem_r <= 1'b0;
    else if (start)           rem_r <= 1'b0;
    else if (accept && last)  rem_r <= rem_neg;
  end

  assign quotient = rem_r ? qm_r : q_r;
`else
  logic unused_rem_neg;
  assign unused_rem_neg = rem_neg;
  assign quotient = q_r;
`endif

  assign busy  = (state == CONV);
  assign done  = (state == DONE);
  assign q_err = err_r;

endmodule
